// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit:
// op encodings, FSM states, default latencies and a small helper.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_RSV6  = 3'd6,
        MD_RSV7  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic [31:0] neg_if(
        input logic        c,
        input logic [31:0] v
    );
        return c ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
// Ports: clk, reset (async, active-high), start, md_op[2:0],
//        src_a[31:0], src_b[31:0] in; busy, hi[31:0], lo[31:0] out.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ?
                             MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    md_state_e     state;
    logic [CW-1:0] cnt;
    md_op_e        op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;

    md_op_e        op_in;
    logic          in_mul;
    logic          in_div;

    assign op_in  = md_op_e'(md_op);
    assign in_mul = (op_in == MD_MULT) || (op_in == MD_MULTU);
    assign in_div = (op_in == MD_DIV) || (op_in == MD_DIVU);

    // Multiply: extend to 64 bits, the low 64 product bits are
    // correct for both signed and unsigned operands.
    logic        mul_s;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;

    assign mul_s = (op_q == MD_MULT);
    assign ext_a = {{32{mul_s & a_q[31]}}, a_q};
    assign ext_b = {{32{mul_s & b_q[31]}}, b_q};
    assign prod  = ext_a * ext_b;

    // Divide: unsigned core on magnitudes, signs fixed afterwards.
    // 0x80000000 / -1 falls out as quotient 0x80000000, rem 0.
    logic        div_s;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] den;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;

    assign div_s = (op_q == MD_DIV);
    assign neg_a = div_s & a_q[31];
    assign neg_b = div_s & b_q[31];
    assign mag_a = neg_if(neg_a, a_q);
    assign mag_b = neg_if(neg_b, b_q);
    assign den   = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign uq    = mag_a / den;
    assign ur    = mag_a % den;
    assign quot  = neg_if(neg_a ^ neg_b, uq);
    assign rem   = neg_if(neg_a, ur);

    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_ok;

    always_comb begin
        pend_hi = hi;
        pend_lo = lo;
        pend_ok = 1'b0;
        unique case (1'b1)
            (op_q == MD_MULT) || (op_q == MD_MULTU): begin
                pend_hi = prod[63:32];
                pend_lo = prod[31:0];
                pend_ok = 1'b1;
            end
            (op_q == MD_DIV) || (op_q == MD_DIVU): begin
                pend_hi = rem;
                pend_lo = quot;
                pend_ok = (b_q != 32'd0);
            end
            default: pend_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= MD_MULT;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        unique case (1'b1)
                            in_mul || in_div: begin
                                state <= ST_RUN;
                                busy  <= 1'b1;
                                cnt   <= in_mul ? MUL_CNT : DIV_CNT;
                                op_q  <= op_in;
                                a_q   <= src_a;
                                b_q   <= src_b;
                            end
                            op_in == MD_MTHI: hi <= src_a;
                            op_in == MD_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (cnt == ONE_CNT) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        if (pend_ok) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                    end else begin
                        cnt <= cnt - ONE_CNT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Issue logic must never start an op while one is in flight.
    a_no_start_busy: assert property (
        @(posedge clk) disable iff (reset) !(start && busy)
    );

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit.
// Scoreboard of expected HI/LO/latency checked when busy drops.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    localparam int MCYC  = 5;
    localparam int DCYC  = 10;
    localparam int BOUND = 40;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb_q[$];

    mul_div_unit #(
        .MULT_CYCLES(MCYC),
        .DIV_CYCLES (DCYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .md_op(md_op),
        .src_a(src_a),
        .src_b(src_b),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        e.hi     = m_hi;
        e.lo     = m_lo;
        e.cycles = 0;
        case (op)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.cycles = MCYC;
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.cycles = MCYC;
            end
            3'd2, 3'd3: begin
                e.cycles = DCYC;
                if (b != 32'd0) begin
                    if (op == 3'd2) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'd0, a});
                        sb = longint'({32'd0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
            3'd4: e.hi = a;
            3'd5: e.lo = a;
            default: ;
        endcase
        return e;
    endfunction

    task automatic run_op(
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input bit          wiggle,
        input string       name
    );
        exp_t        e;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          n;
        sb_q.push_back(model(op, a, b));
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        src_a  = a;
        src_b  = b;
        old_hi = hi;
        old_lo = lo;
        @(negedge clk);
        start = 1'b0;
        if (wiggle) begin
            src_a = $urandom;
            src_b = $urandom;
        end
        n = 0;
        while (busy === 1'b1 && n < BOUND) begin
            n++;
            n_cmp++;
            if (hi !== old_hi || lo !== old_lo) begin
                n_bad++;
                $display("FAIL %s hold c%0d: hi=%h lo=%h want %h %h",
                         name, n, hi, lo, old_hi, old_lo);
            end
            @(negedge clk);
            if (wiggle) begin
                src_a = $urandom;
                src_b = $urandom;
            end
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (n !== e.cycles) begin
            n_bad++;
            $display("FAIL %s busy_cycles: got %0d want %0d",
                     name, n, e.cycles);
        end
        n_cmp++;
        if (hi !== e.hi) begin
            n_bad++;
            $display("FAIL %s hi: got %h want %h", name, hi, e.hi);
        end
        n_cmp++;
        if (lo !== e.lo) begin
            n_bad++;
            $display("FAIL %s lo: got %h want %h", name, lo, e.lo);
        end
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        src_a = 32'd0;
        src_b = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_bad++;
            $display("FAIL reset: busy=%b hi=%h lo=%h want 0 0 0",
                     busy, hi, lo);
        end
    endtask

    task automatic test_mult();
        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult");
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_min");
    endtask

    task automatic test_multu();
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    endtask

    task automatic test_div();
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, "divu");
        run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_negb");
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    endtask

    task automatic test_div_zero();
        run_op(3'd4, 32'h11, 32'd0, 1'b0, "mthi_prep");
        run_op(3'd5, 32'h22, 32'd0, 1'b0, "mtlo_prep");
        run_op(3'd3, 32'd7, 32'd0, 1'b0, "divu_zero");
        run_op(3'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, "div_zero");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd4;
        src_a = 32'hDEAD_BEEF;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL mthi_b2b: busy=%b hi=%h want 0 deadbeef",
                     busy, hi);
        end
        md_op = 3'd5;
        src_a = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'hDEAD_BEEF ||
            lo !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL mtlo_b2b: busy=%b hi=%h lo=%h want 0 %h %h",
                     busy, hi, lo, 32'hDEAD_BEEF, 32'h1234_5678);
        end
        m_hi = 32'hDEAD_BEEF;
        m_lo = 32'h1234_5678;
    endtask

    task automatic test_operand_change();
        run_op(3'd0, 32'h0001_2345, 32'hFFFF_0003, 1'b1, "mult_wiggle");
        run_op(3'd3, 32'hCAFE_F00D, 32'd1234, 1'b1, "divu_wiggle");
    endtask

    task automatic test_reserved();
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd6;
        src_a = 32'hAAAA_5555;
        src_b = 32'd9;
        @(negedge clk);
        md_op = 3'd7;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            n_bad++;
            $display("FAIL reserved: busy=%b hi=%h lo=%h want 0 %h %h",
                     busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start = 1'b1;
        md_op = 3'd2;
        src_a = 32'd100;
        src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_busy: got %b want 1", busy);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_bad++;
            $display("FAIL async_reset: busy=%b hi=%h lo=%h want 0 0 0",
                     busy, hi, lo);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        run_op(3'd0, 32'd7, 32'd6, 1'b0, "mult_after_rst");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_operand_change();
        test_reserved();
        test_reset_mid_run();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
